// File: rtl/seq_divider.sv
// Sequential restoring divider: 16-bit dividend by 8-bit divisor, one quotient
// bit per clock, with enable-level load/run control and a divide-by-zero flag.
module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic [15:0] Q,
    output logic [7:0]  R,
    output logic        done,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [15:0] a_reg;
    logic [7:0]  b_reg;
    logic [15:0] q_sh;
    logic [8:0]  p;
    logic [4:0]  count;

    logic [8:0]  t;
    logic [8:0]  p_next;
    logic        q_bit;

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    always_comb begin
        t      = {p[7:0], q_sh[15]};
        p_next = t;
        q_bit  = 1'b0;
        if (t >= {1'b0, b_reg}) begin
            p_next = t - {1'b0, b_reg};
            q_bit  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            q_sh  <= '0;
            p     <= '0;
            count <= '0;
            Q     <= '0;
            R     <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!enable) begin
                        a_reg <= A;
                        b_reg <= B;
                        Q     <= '0;
                        R     <= '0;
                        done  <= 1'b0;
                        dz    <= 1'b0;
                        count <= '0;
                    end else if (b_reg == 8'd0) begin
                        state <= DONE;
                        Q     <= 16'hFFFF;
                        R     <= a_reg[7:0];
                        dz    <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                        q_sh  <= a_reg;
                        p     <= '0;
                        count <= '0;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        // Abort: nothing partial ever reaches the outputs.
                        state <= IDLE;
                        a_reg <= A;
                        b_reg <= B;
                        Q     <= '0;
                        R     <= '0;
                        done  <= 1'b0;
                        dz    <= 1'b0;
                        count <= '0;
                    end else begin
                        p     <= p_next;
                        q_sh  <= {q_sh[14:0], q_bit};
                        count <= count + 5'd1;
                        if (count == 5'd15) begin
                            state <= DONE;
                            Q     <= {q_sh[14:0], q_bit};
                            R     <= p_next[7:0];
                            done  <= 1'b1;
                            dz    <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                        a_reg <= A;
                        b_reg <= B;
                        Q     <= '0;
                        R     <= '0;
                        done  <= 1'b0;
                        dz    <= 1'b0;
                        count <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes reference results computed
// with plain / and %, a negedge monitor checks each done rise and idle outputs.
`timescale 1ns/1ps
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] A;
    logic [7:0]  B;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        done;
    logic        dz;

    seq_divider dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .A      (A),
        .B      (B),
        .Q      (Q),
        .R      (R),
        .done   (done),
        .dz     (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic done_prev = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares on each done rise, then watches held and idle outputs.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_done", {Q, R, 7'd0, dz}, 32'd0);
            end else begin
                cur = sb.pop_front();
                check(cyc == cur.cyc, "latency", cyc, cur.cyc);
                check(Q == cur.q, "quotient", {16'd0, Q}, {16'd0, cur.q});
                check(R == cur.r, "remainder", {24'd0, R}, {24'd0, cur.r});
                check(dz == cur.dz, "dz", {31'd0, dz}, {31'd0, cur.dz});
            end
        end else if (done) begin
            check(Q == cur.q && R == cur.r && dz == cur.dz, "hold",
                  {Q, R, 7'd0, dz}, {cur.q, cur.r, 7'd0, cur.dz});
        end else begin
            check(Q == 16'd0 && R == 8'd0 && dz == 1'b0, "idle_zero",
                  {Q, R, 7'd0, dz}, 32'd0);
        end
        if (sb.size() > 0 && !done && cyc > sb[0].cyc) begin
            check(1'b0, "done_timeout", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned integer division; zero divisor gives all-ones quotient.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int start);
        exp_t e;
        if (b == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.dz  = 1'b1;
            e.cyc = start + 1;
        end else begin
            e.q   = a / {8'd0, b};
            e.r   = 8'(a % {8'd0, b});
            e.dz  = 1'b0;
            e.cyc = start + 17;
        end
        return e;
    endfunction

    // abort_after < 0: full run; otherwise drop enable after that many RUN edges.
    task automatic do_run(input logic [15:0] a, input logic [7:0] b,
                          input int abort_after, input int hold, input bit scramble);
        int lat;
        enable = 1'b0;
        A = a;
        B = b;
        tick();
        tick();
        lat = (b == 8'd0) ? 1 : 17;
        if (abort_after < 0) sb.push_back(model(a, b, cyc));
        enable = 1'b1;
        if (abort_after >= 0) begin
            repeat (abort_after + 1) begin
                tick();
                if (scramble) begin
                    A = 16'($urandom);
                    B = 8'($urandom);
                end
            end
            enable = 1'b0;
            tick();
        end else begin
            repeat (lat + hold) begin
                tick();
                if (scramble) begin
                    A = 16'($urandom);
                    B = 8'($urandom);
                end
            end
            enable = 1'b0;
            tick();
        end
    endtask

    task automatic reset_pulse_check(input string name);
        #1 rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check(Q == 16'd0 && R == 8'd0 && done == 1'b0 && dz == 1'b0, name,
              {Q, R, 6'd0, done, dz}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        A      = '0;
        B      = '0;
        repeat (5) begin
            A      = 16'($urandom);
            B      = 8'($urandom);
            enable = 1'($urandom);
            tick();
            check(Q == 16'd0 && R == 8'd0 && done == 1'b0 && dz == 1'b0, "reset_state",
                  {Q, R, 6'd0, done, dz}, 32'd0);
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        tick();
        tick();

        do_run(16'h07F8, 8'h18, -1, 4, 1'b1);
        do_run(16'h26DA, 8'h41, -1, 1, 1'b0);
        do_run(16'hFFFF, 8'hFF, -1, 2, 1'b1);
        do_run(16'hFFFF, 8'h01, -1, 0, 1'b0);
        do_run(16'h1234, 8'h00, -1, 3, 1'b1);

        // Abort after 8 RUN edges, then a clean re-run of the same operands.
        do_run(16'h26D9, 8'h41, 8, 0, 1'b0);
        do_run(16'h26D9, 8'h41, -1, 1, 1'b0);

        // Reset pulse mid-RUN, then reset pulse while holding a result.
        enable = 1'b0;
        A = 16'hBEEF;
        B = 8'h07;
        tick();
        tick();
        enable = 1'b1;
        repeat (6) tick();
        reset_pulse_check("async_reset_run");
        tick();

        A = 16'hBEEF;
        B = 8'h07;
        tick();
        sb.push_back(model(A, B, cyc));
        enable = 1'b1;
        repeat (19) tick();
        reset_pulse_check("async_reset_done");
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            ra = 16'($urandom);
            rb = ($urandom_range(15, 0) == 0) ? 8'd0 : 8'($urandom);
            if (rb != 8'd0 && $urandom_range(7, 0) == 0)
                do_run(ra, rb, int'($urandom_range(15, 0)), 0, 1'b1);
            else
                do_run(ra, rb, -1, int'($urandom_range(3, 0)), 1'($urandom));
        end

        repeat (4) tick();
        check(sb.size() == 0, "pending_results", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
